decode_hazard_ctrl: RTL and testbench

Pipeline interlock controller for the decode stage of the 64-bit RV pipeline (R-type, ld, sd, beq).
- Watches the instruction in IF/ID and keeps its own shadow of the ID/EX destination.
- Drives PC / IF/ID / ID/EX write-enables, flush and bubble controls for load-use stalls, taken-branch squashes and data-memory wait freezes.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/rv_pkg.sv | 17 +
 rtl/hazard_operand_decode.sv | 15 +
 rtl/decode_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_decode_hazard_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: opcodes, interlock states and instruction field helpers shared by the decode hazard logic
package rv_pkg;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  function automatic logic [4:0] f_rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction
endpackage

// File: rtl/hazard_operand_decode.sv
// hazard_operand_decode: opcode -> source-register use, destination write and load flags
module hazard_operand_decode
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_writes_rd,
  output logic       o_is_ld
);
  assign o_uses_rs1 = i_opcode == OP_RTYPE || i_opcode == OP_LD || i_opcode == OP_SD || i_opcode == OP_BEQ;
  assign o_uses_rs2 = i_opcode == OP_RTYPE || i_opcode == OP_SD || i_opcode == OP_BEQ;
  assign o_writes_rd = i_opcode == OP_RTYPE || i_opcode == OP_LD;
  assign o_is_ld = i_opcode == OP_LD;
endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage interlock (load-use stall, branch squash, memory freeze) with perf counters
module decode_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_inst,
  input  logic             id_valid,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  localparam logic [2:0] LP_REM = 3'(BRANCH_PENALTY - 1);
  localparam logic [15:0] LP_TO = 16'(MEM_TIMEOUT - 1);
  state_t r_state, w_state_nxt;
  logic [2:0] r_rem, w_rem_nxt;
  logic [4:0] r_ex_rd;
  logic r_ex_memread;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [15:0] r_frz;
  logic r_mem_timeout;
  logic w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_ld;
  logic [4:0] w_rs1, w_rs2, w_rd;
  logic w_freeze, w_load_use, w_squash, w_unused;
  hazard_operand_decode u_dec (
    .i_opcode   (if_id_inst[6:0]),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_writes_rd(w_writes_rd),
    .o_is_ld    (w_is_ld)
  );
  assign w_unused = ^{if_id_inst[31:25], if_id_inst[14:12]};
  assign w_rs1 = f_rs1(if_id_inst);
  assign w_rs2 = f_rs2(if_id_inst);
  assign w_rd = f_rd(if_id_inst);
  assign w_freeze = mem_req & ~mem_ready;
  assign w_load_use = id_valid & r_ex_memread & (r_ex_rd != 5'd0) &
                      ((w_uses_rs1 & (w_rs1 == r_ex_rd)) | (w_uses_rs2 & (w_rs2 == r_ex_rd)));
  // FLUSH squashes regardless of branch_taken; RUN squashes only on a taken branch
  assign w_squash = (r_state == ST_FLUSH) | branch_taken;
  always_comb begin
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_freeze) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
    end else if (w_squash) begin
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt = r_rem;
    if (r_state == ST_FLUSH) begin
      w_rem_nxt = r_rem - 3'd1;
      w_state_nxt = r_rem == 3'd1 ? ST_RUN : ST_FLUSH;
    end else if (branch_taken && BRANCH_PENALTY > 1) begin
      w_state_nxt = ST_FLUSH;
      w_rem_nxt = LP_REM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_rem <= 3'd0;
      r_ex_rd <= 5'd0;
      r_ex_memread <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_frz <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else if (w_freeze) begin
      r_frz <= &r_frz ? r_frz : r_frz + 16'd1;
      if (r_frz >= LP_TO) r_mem_timeout <= 1'b1;
    end else begin
      r_frz <= 16'd0;
      r_state <= w_state_nxt;
      r_rem <= w_rem_nxt;
      r_ex_rd <= (id_ex_bubble | ~id_valid | ~w_writes_rd) ? 5'd0 : w_rd;
      r_ex_memread <= ~id_ex_bubble & id_valid & w_is_ld;
      if (w_squash && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (!w_squash && w_load_use && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign mem_timeout = r_mem_timeout;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: directed plus random stimulus against a cycle-level interlock model via a scoreboard queue
module tb_decode_hazard_ctrl;
  localparam int BP = 3;
  localparam int MT = 5;
  localparam int CW = 4;
  localparam int CMAX = 15;
  localparam logic [6:0] RT = 7'b0110011, LD = 7'b0000011, SD = 7'b0100011, BQ = 7'b1100011;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {
    logic pc, ifw, fl, idw, bub, exw;
    logic [CW-1:0] sc, fc;
    logic to;
  } exp_t;
  logic clk = 1'b0;
  logic reset, id_valid, branch_taken, mem_req, mem_ready;
  logic [31:0] if_id_inst;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_rd = 0, m_left = 0, m_sc = 0, m_fc = 0, m_streak = 0;
  logic m_memrd = 1'b0, m_to = 1'b0;
  decode_hazard_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_id_inst(if_id_inst), .id_valid(id_valid),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction
  task automatic step(input logic rst, input logic [31:0] inst, input logic v, input logic br,
                      input logic mq, input logic mr);
    exp_t e;
    logic [6:0] op;
    int rd, rs1, rs2;
    logic u1, u2, wr, ld, lu, bub;
    @(posedge clk);
    #1;
    reset = rst; if_id_inst = inst; id_valid = v; branch_taken = br; mem_req = mq; mem_ready = mr;
    op = inst[6:0];
    rd = int'(inst[11:7]);
    rs1 = int'(inst[19:15]);
    rs2 = int'(inst[24:20]);
    u1 = op == RT || op == LD || op == SD || op == BQ;
    u2 = op == RT || op == SD || op == BQ;
    wr = op == RT || op == LD;
    ld = op == LD;
    lu = v && m_memrd && m_rd != 0 && ((u1 && rs1 == m_rd) || (u2 && rs2 == m_rd));
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
    e.to = m_to;
    if (rst) begin
      {e.pc, e.ifw, e.fl, e.idw, e.bub, e.exw} = 6'b001010;
      m_rd = 0; m_memrd = 0; m_left = 0; m_sc = 0; m_fc = 0; m_streak = 0; m_to = 0;
    end else if (mq && !mr) begin
      {e.pc, e.ifw, e.fl, e.idw, e.bub, e.exw} = 6'b000000;
      m_streak++;
      if (m_streak >= MT) m_to = 1;
    end else begin
      m_streak = 0;
      if (m_left > 0 || br) begin
        {e.pc, e.ifw, e.fl, e.idw, e.bub, e.exw} = 6'b111111;
        m_left = m_left > 0 ? m_left - 1 : BP - 1;
        m_fc = m_fc == CMAX ? CMAX : m_fc + 1;
        bub = 1;
      end else if (lu) begin
        {e.pc, e.ifw, e.fl, e.idw, e.bub, e.exw} = 6'b000111;
        m_sc = m_sc == CMAX ? CMAX : m_sc + 1;
        bub = 1;
      end else begin
        {e.pc, e.ifw, e.fl, e.idw, e.bub, e.exw} = 6'b110101;
        bub = 0;
      end
      m_rd = (bub || !v || !wr) ? 0 : rd;
      m_memrd = !bub && v && ld;
    end
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e, act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
             stall_cnt, flush_cnt, mem_timeout};
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outs t=%0t: actual=%h required=%h", $time, act, e);
      end
    end
  end
  initial begin
    logic [6:0] ops[6];
    ops = '{RT, LD, SD, BQ, 7'b0010011, 7'b1111111};
    reset = 1; if_id_inst = NOP; id_valid = 1; branch_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk);
    repeat (3) step(1, NOP, 1, 0, 0, 0);
    step(0, NOP, 1, 0, 0, 0);
    step(0, mk(LD, 5, 1, 0), 1, 0, 0, 0);
    step(0, mk(RT, 6, 5, 2), 1, 0, 0, 0);
    step(0, mk(RT, 6, 5, 2), 1, 0, 0, 0);
    step(0, mk(LD, 5, 1, 0), 1, 0, 0, 0);
    step(0, mk(RT, 6, 7, 2), 1, 0, 0, 0);
    step(0, mk(LD, 0, 1, 0), 1, 0, 0, 0);
    step(0, mk(RT, 6, 0, 0), 1, 0, 0, 0);
    step(0, NOP, 1, 1, 0, 0);
    repeat (4) step(0, NOP, 1, 0, 0, 0);
    step(0, mk(LD, 5, 1, 0), 1, 0, 0, 0);
    repeat (4) step(0, mk(RT, 6, 5, 2), 1, 0, 1, 0);
    step(0, mk(RT, 6, 5, 2), 1, 0, 1, 1);
    step(0, mk(RT, 6, 5, 2), 1, 0, 0, 0);
    repeat (2) step(0, NOP, 1, 1, 1, 0);
    step(0, NOP, 1, 1, 0, 0);
    repeat (3) step(0, NOP, 1, 0, 0, 0);
    repeat (6) step(0, NOP, 1, 0, 1, 0);
    repeat (3) step(0, NOP, 1, 0, 0, 0);
    step(1, NOP, 1, 0, 1, 0);
    repeat (2) step(0, NOP, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic fr;
      fr = $urandom_range(0, 99) < 25;
      step($urandom_range(0, 199) == 0,
           mk(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
           $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, fr | ($urandom_range(0, 9) == 0),
           !fr && $urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
